// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
package imem_loader_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int WORD_W         = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_WRITE,
    ST_VRD,
    ST_VCMP,
    ST_CHECK,
    ST_RUN,
    ST_ERROR
  } loader_state_e;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Little-endian 8->32 packer: byte k of a word lands in bits [8k+7:8k].
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              arst_n,
  input  logic              clr,
  input  logic              in_valid,
  input  logic              in_ready,
  input  logic [7:0]        in_data,
  output logic [WORD_W-1:0] word,
  output logic              word_valid
);

  logic [1:0]        cnt_q, cnt_d;
  logic [WORD_W-1:0] sreg_q, sreg_d;
  logic              take;

  always_comb begin
    take   = in_valid && in_ready;
    cnt_d  = cnt_q;
    sreg_d = sreg_q;
    if (clr) begin
      cnt_d  = '0;
      sreg_d = '0;
    end else if (take) begin
      cnt_d  = cnt_q + 2'd1;
      sreg_d = {in_data, sreg_q[WORD_W-1:8]};
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      cnt_q  <= '0;
      sreg_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      sreg_q <= sreg_d;
    end
  end

  // word_valid flags the edge that accepts the last byte; word is complete the cycle after.
  assign word       = sreg_q;
  assign word_valid = take && (cnt_q == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Boot loader: streams bytes into instruction memory, reads the image back,
// and releases the CPU only if the XOR checksum of the readback matches.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              start,
  input  logic [ADDR_W:0]   num_words,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic [63:0]       addr_ext,
  output logic              wen_ext,
  output logic              ren_ext,
  output logic [WORD_W-1:0] wdata_ext,
  input  logic [WORD_W-1:0] rdata_ext,
  output logic              cpu_enable,
  output logic              busy,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  localparam logic [ADDR_W:0] MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE       = {{ADDR_W{1'b0}}, 1'b1};

  loader_state_e     state_q, state_d;
  logic [ADDR_W:0]   num_q, num_d;
  logic [ADDR_W:0]   word_cnt_q, word_cnt_d;
  logic [ADDR_W:0]   rd_idx_q, rd_idx_d;
  logic [WORD_W-1:0] wsum_q, wsum_d;
  logic [WORD_W-1:0] rsum_q, rsum_d;
  logic [ADDR_W:0]   word_cnt_inc, rd_idx_inc;
  logic [WORD_W-1:0] word;
  logic              word_valid;
  logic              idle_like, start_acc, start_ok;

  assign idle_like    = (state_q == ST_IDLE) || (state_q == ST_RUN) || (state_q == ST_ERROR);
  assign start_acc    = start && idle_like;
  assign start_ok     = (num_words != '0) && (num_words <= MAX_WORDS);
  assign word_cnt_inc = word_cnt_q + ONE;
  assign rd_idx_inc   = rd_idx_q + ONE;

  byte_packer u_packer (
    .clk        (clk),
    .arst_n     (arst_n),
    .clr        (start_acc),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .word       (word),
    .word_valid (word_valid)
  );

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q    <= ST_IDLE;
      num_q      <= '0;
      word_cnt_q <= '0;
      rd_idx_q   <= '0;
      wsum_q     <= '0;
      rsum_q     <= '0;
    end else begin
      state_q    <= state_d;
      num_q      <= num_d;
      word_cnt_q <= word_cnt_d;
      rd_idx_q   <= rd_idx_d;
      wsum_q     <= wsum_d;
      rsum_q     <= rsum_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_RUN, ST_ERROR: if (start) state_d = start_ok ? ST_COLLECT : ST_ERROR;
      ST_COLLECT: if (word_valid) state_d = ST_WRITE;
      ST_WRITE:   state_d = (word_cnt_inc == num_q) ? ST_VRD : ST_COLLECT;
      ST_VRD:     state_d = ST_VCMP;
      ST_VCMP:    state_d = (rd_idx_inc == num_q) ? ST_CHECK : ST_VRD;
      ST_CHECK:   state_d = (rsum_q == wsum_q) ? ST_RUN : ST_ERROR;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Counters and checksums; an accepted start (even a rejected size) clears them.
  always_comb begin
    num_d      = num_q;
    word_cnt_d = word_cnt_q;
    rd_idx_d   = rd_idx_q;
    wsum_d     = wsum_q;
    rsum_d     = rsum_q;
    if (start_acc) begin
      num_d      = num_words;
      word_cnt_d = '0;
      rd_idx_d   = '0;
      wsum_d     = '0;
      rsum_d     = '0;
    end else begin
      case (state_q)
        ST_WRITE: begin
          wsum_d     = wsum_q ^ word;
          word_cnt_d = word_cnt_inc;
          rd_idx_d   = '0;
        end
        ST_VCMP: begin
          rsum_d   = rsum_q ^ rdata_ext;
          rd_idx_d = rd_idx_inc;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    in_ready   = (state_q == ST_COLLECT);
    wen_ext    = (state_q == ST_WRITE);
    ren_ext    = (state_q == ST_VRD);
    cpu_enable = (state_q == ST_RUN);
    error      = (state_q == ST_ERROR);
    busy       = !idle_like;
    addr_ext   = '0;
    wdata_ext  = '0;
    if (state_q == ST_WRITE) begin
      addr_ext  = {{(62 - ADDR_W){1'b0}}, word_cnt_q[ADDR_W-1:0], 2'b00};
      wdata_ext = word;
    end else if (state_q == ST_VRD) begin
      addr_ext = {{(62 - ADDR_W){1'b0}}, rd_idx_q[ADDR_W-1:0], 2'b00};
    end
  end

  assign words_loaded = word_cnt_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: memory model, byte-stream driver and a word-level reference model.
module tb_imem_loader;

  localparam int ADDR_W = 9;
  localparam int NMAX   = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              arst_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W:0]   num_words = '0;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = 8'h00;
  logic              in_ready;
  logic [63:0]       addr_ext;
  logic              wen_ext, ren_ext;
  logic [31:0]       wdata_ext;
  logic [31:0]       rdata_ext;
  logic              cpu_enable, busy, error;
  logic [ADDR_W:0]   words_loaded;

  always #5 clk = ~clk;

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .arst_n       (arst_n),
    .start        (start),
    .num_words    (num_words),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .addr_ext     (addr_ext),
    .wen_ext      (wen_ext),
    .ren_ext      (ren_ext),
    .wdata_ext    (wdata_ext),
    .rdata_ext    (rdata_ext),
    .cpu_enable   (cpu_enable),
    .busy         (busy),
    .error        (error),
    .words_loaded (words_loaded)
  );

  // Instruction memory with one-cycle read latency and an optional bit-0 fault on word 1.
  logic [31:0] mem [NMAX];
  bit          corrupt;
  int          cyc, n_wen, n_ren, n_hs, viol;
  logic [63:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (wen_ext) begin
      mem[addr_ext[ADDR_W+1:2]] <= wdata_ext;
      wr_addr_q.push_back(addr_ext);
      wr_data_q.push_back(wdata_ext);
      n_wen <= n_wen + 1;
    end
    if (ren_ext) begin
      rdata_ext <= mem[addr_ext[ADDR_W+1:2]] ^
                   ((corrupt && addr_ext[ADDR_W+1:2] == 9'd1) ? 32'h1 : 32'h0);
      n_ren <= n_ren + 1;
    end
    if (in_valid && in_ready) n_hs <= n_hs + 1;
    if ((wen_ext && ren_ext) || (addr_ext[63:ADDR_W+2] != '0)) viol <= viol + 1;
  end

  int          errors, checks;
  int          t0;
  logic [7:0]  bytes_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fill_rand(input int n);
    bytes_q.delete();
    repeat (4 * n) bytes_q.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic do_start(input int n);
    logic [31:0] nv;
    nv = 32'(n);
    @(negedge clk);
    start     = 1'b1;
    num_words = nv[ADDR_W:0];
    @(negedge clk);
    start = 1'b0;
    t0    = cyc;
  endtask

  // mode 0: valid held high, 1: toggled every other cycle, 2: random stalls
  task automatic send_bytes(input int mode);
    int idx, g;
    idx = 0;
    g   = 0;
    while (idx < bytes_q.size() && g < 50000) begin
      case (mode)
        0:       in_valid = 1'b1;
        1:       in_valid = ((g % 2) == 0);
        default: in_valid = ($urandom_range(0, 3) != 0);
      endcase
      in_data = bytes_q[idx];
      if (in_valid && in_ready) idx++;
      g++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("bytes_sent", idx, bytes_q.size());
  endtask

  task automatic wait_done(output int lat);
    int g;
    g = 0;
    while (!(cpu_enable || error) && g < 5000) begin
      @(negedge clk);
      g++;
    end
    lat = cyc - t0;
    chk("done_in_time", {63'b0, cpu_enable | error}, 64'd1);
  endtask

  // Reference: word i is bytes 4i..4i+3 little-endian at byte address 4i; the image
  // is accepted iff the XOR of what comes back equals the XOR of what was written.
  task automatic verify(input int n, input int base, input int lat, input int mode);
    logic [31:0] w, xw, xr;
    bit          exp_run;
    xw = '0;
    xr = '0;
    chk("n_writes", wr_addr_q.size() - base, n);
    for (int i = 0; i < n; i++) begin
      w = '0;
      for (int k = 0; k < 4; k++) w = w + (32'(bytes_q[4*i+k]) << (8 * k));
      xw = xw ^ w;
      xr = xr ^ ((corrupt && i == 1) ? (w ^ 32'h1) : w);
      if (base + i < wr_addr_q.size()) begin
        chk("waddr", wr_addr_q[base+i], 64'(4 * i));
        chk("wdata", wr_data_q[base+i], w);
      end
    end
    exp_run = (xw == xr);
    chk("cpu_enable", cpu_enable, exp_run);
    chk("error", error, !exp_run);
    chk("busy_end", busy, 0);
    chk("words_loaded", words_loaded, n);
    if (mode == 0) chk("latency", lat, 7 * n + 1);
  endtask

  task automatic load(input int n, input int mode);
    int base, lat;
    base = wr_addr_q.size();
    do_start(n);
    send_bytes(mode);
    wait_done(lat);
    verify(n, base, lat, mode);
  endtask

  initial begin
    int base, lat, s_wen, s_ren, s_hs, g, n, mode;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_ctrl", {in_ready, wen_ext, ren_ext, cpu_enable, busy, error}, 0);
    chk("rst_addr", addr_ext, 0);
    chk("rst_wdata", wdata_ext, 0);
    chk("rst_words", words_loaded, 0);
    arst_n = 1'b1;

    // Reset after two bytes of a word, then a clean single-word load
    bytes_q = '{8'hAA, 8'hBB};
    do_start(1);
    send_bytes(0);
    chk("collect_mid", in_ready, 1);
    #2 arst_n = 1'b0;
    #1;
    chk("arst_ctrl", {in_ready, wen_ext, ren_ext, cpu_enable, busy, error}, 0);
    chk("arst_addr", addr_ext, 0);
    chk("arst_words", words_loaded, 0);
    @(negedge clk);
    arst_n = 1'b1;
    bytes_q = '{8'h13, 8'h00, 8'h00, 8'h00};
    base = wr_addr_q.size();
    load(1, 0);
    if (wr_data_q.size() > base) chk("after_rst_word", wr_data_q[base], 32'h0000_0013);

    // Two-word program, no stalls
    bytes_q = '{8'h93, 8'h00, 8'h10, 8'h00, 8'h13, 8'h01, 8'h20, 8'h00};
    base = wr_addr_q.size();
    load(2, 0);
    if (wr_data_q.size() > base + 1) begin
      chk("w0", wr_data_q[base], 32'h0010_0093);
      chk("w1", wr_data_q[base+1], 32'h0020_0113);
    end

    // Valid toggling every other cycle
    fill_rand(1);
    s_hs  = n_hs;
    s_wen = n_wen;
    load(1, 1);
    chk("handshakes", n_hs - s_hs, 4);
    chk("wen_pulses", n_wen - s_wen, 1);

    // Checksum failure, then a good load recovers
    corrupt = 1'b1;
    fill_rand(3);
    load(3, 0);
    corrupt = 1'b0;
    fill_rand(2);
    load(2, 2);

    // num_words = 0
    s_wen = n_wen;
    s_ren = n_ren;
    do_start(0);
    chk("n0_error", error, 1);
    chk("n0_busy", busy, 0);
    @(negedge clk);
    chk("n0_nomem", {n_wen - s_wen, n_ren - s_ren}, 0);

    // num_words = 513
    do_start(NMAX + 1);
    chk("n513_error", error, 1);
    chk("n513_words", words_loaded, 0);

    // num_words = 512 fills the whole memory
    fill_rand(NMAX);
    base = wr_addr_q.size();
    load(NMAX, 0);
    if (wr_addr_q.size() >= base + NMAX) chk("last_addr", wr_addr_q[base+NMAX-1], 64'h7FC);

    // start during VRD is ignored
    fill_rand(2);
    base = wr_addr_q.size();
    do_start(2);
    send_bytes(0);
    g = 0;
    while (!ren_ext && g < 200) begin
      @(negedge clk);
      g++;
    end
    chk("vrd_seen", ren_ext, 1);
    start     = 1'b1;
    num_words = 10'd1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat);
    verify(2, base, lat, 0);

    // start in RUN restarts immediately
    fill_rand(1);
    base = wr_addr_q.size();
    do_start(1);
    chk("rerun_cpu", cpu_enable, 0);
    chk("rerun_words", words_loaded, 0);
    chk("rerun_ready", in_ready, 1);
    send_bytes(0);
    wait_done(lat);
    verify(1, base, lat, 0);

    // Randomized loads
    for (int r = 0; r < 6; r++) begin
      n       = $urandom_range(1, 12);
      mode    = $urandom_range(0, 2);
      corrupt = (n > 1) && ($urandom_range(0, 2) == 0);
      fill_rand(n);
      load(n, mode);
    end
    corrupt = 1'b0;

    chk("invariants", viol, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
